// File: rtl/ecc_scalar_mult.sv
// Left-to-right double-and-add scalar multiplication controller (Q = k*P).
// Sequences one add/double request at a time to the downstream adddouble unit.
module ecc_scalar_mult #(
    parameter int unsigned K_WIDTH  = 64,
    parameter int unsigned PT_WIDTH = 129,
    parameter logic [1:0]  OP_ADD   = 2'd0,
    parameter logic [1:0]  OP_DBL   = 2'd2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_WIDTH-1:0]  k,
    input  logic [PT_WIDTH-1:0] p_in,
    output logic                busy,
    output logic                done,
    output logic [PT_WIDTH-1:0] q_out,
    output logic                ad_enable,
    output logic [1:0]          ad_op,
    output logic [PT_WIDTH-1:0] ad_p,
    output logic [PT_WIDTH-1:0] ad_q,
    input  logic [PT_WIDTH-1:0] ad_T,
    input  logic                ad_done
);

    localparam int unsigned IDX_W   = $clog2(K_WIDTH);
    localparam int unsigned INF_BIT = PT_WIDTH - 1;
    localparam logic [PT_WIDTH-1:0] PT_INF = {1'b1, {(PT_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]    IDX_TOP = IDX_W'(K_WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_DBL_REQ,
        S_DBL_WAIT,
        S_BIT,
        S_ADD_REQ,
        S_ADD_WAIT,
        S_NEXT,
        S_FINISH
    } state_e;

    state_e              state_q, state_d;
    logic [K_WIDTH-1:0]  k_q, k_d;
    logic [PT_WIDTH-1:0] p_q, p_d;
    logic [PT_WIDTH-1:0] r_q, r_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PT_WIDTH-1:0] q_out_q, q_out_d;
    logic                ad_enable_q, ad_enable_d;
    logic [1:0]          ad_op_q, ad_op_d;
    logic [PT_WIDTH-1:0] ad_p_q, ad_p_d;
    logic [PT_WIDTH-1:0] ad_q_q, ad_q_d;

    logic trivial_c;
    logic [PT_WIDTH-1:0] result_c;

    // A zero scalar or infinite base point short-circuits to infinity.
    assign trivial_c = p_q[INF_BIT] | (k_q == '0);
    assign result_c  = trivial_c ? PT_INF : r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            p_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            q_out_q     <= PT_INF;
            ad_enable_q <= 1'b0;
            ad_op_q     <= OP_ADD;
            ad_p_q      <= '0;
            ad_q_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            p_q         <= p_d;
            r_q         <= r_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            q_out_q     <= q_out_d;
            ad_enable_q <= ad_enable_d;
            ad_op_q     <= ad_op_d;
            ad_p_q      <= ad_p_d;
            ad_q_q      <= ad_q_d;
        end
    end

    // Outputs are registered: request/done strobes are set on entry to their state.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        p_d         = p_q;
        r_d         = r_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        q_out_d     = q_out_q;
        ad_enable_d = 1'b0;
        ad_op_d     = ad_op_q;
        ad_p_d      = ad_p_q;
        ad_q_d      = ad_q_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k;
                    p_d     = p_in;
                    r_d     = PT_INF;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (trivial_c) begin
                    done_d  = 1'b1;
                    q_out_d = result_c;
                    state_d = S_FINISH;
                end else if (!r_q[INF_BIT]) begin
                    ad_enable_d = 1'b1;
                    ad_op_d     = OP_DBL;
                    ad_p_d      = r_q;
                    ad_q_d      = r_q;
                    state_d     = S_DBL_REQ;
                end else begin
                    // Leading-zero skip: doubling infinity is pointless.
                    state_d = S_BIT;
                end
            end
            S_DBL_REQ: state_d = S_DBL_WAIT;
            S_DBL_WAIT: begin
                if (ad_done) begin
                    r_d     = ad_T;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                if (!k_q[idx_q]) begin
                    state_d = S_NEXT;
                end else if (r_q[INF_BIT]) begin
                    r_d     = p_q;
                    state_d = S_NEXT;
                end else begin
                    ad_enable_d = 1'b1;
                    ad_op_d     = OP_ADD;
                    ad_p_d      = r_q;
                    ad_q_d      = p_q;
                    state_d     = S_ADD_REQ;
                end
            end
            S_ADD_REQ: state_d = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (ad_done) begin
                    r_d     = ad_T;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    done_d  = 1'b1;
                    q_out_d = result_c;
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = S_SCAN;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign q_out     = q_out_q;
    assign ad_enable = ad_enable_q;
    assign ad_op     = ad_op_q;
    assign ad_p      = ad_p_q;
    assign ad_q      = ad_q_q;

endmodule

// File: tb/tb_ecc_scalar_mult.sv
// Randomized self-checking bench for ecc_scalar_mult with a 6-cycle adddouble stand-in.
module tb_ecc_scalar_mult;

    localparam logic [1:0]   OP_ADD = 2'd0;
    localparam logic [1:0]   OP_DBL = 2'd2;
    localparam logic [128:0] INF    = {1'b1, 128'd0};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  k;
    logic [128:0] p_in;
    logic         busy;
    logic         done;
    logic [128:0] q_out;
    logic         ad_enable;
    logic [1:0]   ad_op;
    logic [128:0] ad_p;
    logic [128:0] ad_q;
    logic [128:0] ad_T;
    logic         ad_done;

    int errs   = 0;
    int checks = 0;

    int           n_req = 0;
    logic [1:0]   op_log[$];
    logic [128:0] q_log[$];
    bit           outstanding = 0;

    ecc_scalar_mult dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .p_in      (p_in),
        .busy      (busy),
        .done      (done),
        .q_out     (q_out),
        .ad_enable (ad_enable),
        .ad_op     (ad_op),
        .ad_p      (ad_p),
        .ad_q      (ad_q),
        .ad_T      (ad_T),
        .ad_done   (ad_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Point add/double stand-in: fixed latency, operates on x only.
    initial begin
        logic [1:0]   op;
        logic [128:0] a, b;
        ad_done = 1'b0;
        ad_T    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ad_enable) begin
                op = ad_op;
                a  = ad_p;
                b  = ad_q;
                repeat (5) @(posedge clk);
                #1;
                if (op == OP_DBL) ad_T = {1'b0, a[127:64] << 1, 64'd0};
                else              ad_T = {1'b0, a[127:64] + b[127:64], 64'd0};
                ad_done = 1'b1;
                @(posedge clk);
                #1;
                ad_done = 1'b0;
            end
        end
    end

    // Request log and single-outstanding monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (ad_done) outstanding = 0;
            if (ad_enable && rst) begin
                check("one_outstanding", 129'(outstanding), 129'(0));
                outstanding = 1;
                n_req++;
                op_log.push_back(ad_op);
                q_log.push_back(ad_q);
            end
        end
    end

    task automatic run_mult(input string tag, input logic [63:0] kk, input logic [128:0] pp,
                            input int poke);
        logic [1:0]   exp_ops[$];
        logic [128:0] exp_q;
        bit           first;
        bit           busy_ok;
        int           cycles;
        int           bad;
        // Reference: leading one loads P, every later bit doubles, set bits add.
        first = 1;
        for (int i = 63; i >= 0; i--) begin
            if (!first) exp_ops.push_back(OP_DBL);
            if (kk[i]) begin
                if (!first) exp_ops.push_back(OP_ADD);
                first = 0;
            end
        end
        if (kk == 64'd0 || pp[128]) begin
            exp_q = INF;
            exp_ops.delete();
        end else if (kk == 64'd1) begin
            exp_q = pp;
        end else begin
            exp_q = {1'b0, kk * pp[127:64], 64'd0};
        end

        op_log.delete();
        q_log.delete();
        n_req = 0;
        @(negedge clk);
        k     = kk;
        p_in  = pp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = {$urandom, $urandom};
        p_in  = {1'b0, $urandom, $urandom, $urandom, $urandom};
        cycles  = 0;
        busy_ok = 1;
        while (!done && cycles < 5000) begin
            if (!busy) busy_ok = 0;
            start = (poke != 0 && cycles == poke);
            if (start) begin
                k    = 64'd7;
                p_in = {1'b0, 64'd3, 64'd0};
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 129'(0), 129'(1));
            return;
        end
        check({tag, "_busy_run"}, 129'(busy_ok & busy), 129'(1));
        check({tag, "_q_out"}, q_out, exp_q);
        @(negedge clk);
        check({tag, "_done_pulse"}, 129'(done), 129'(0));
        check({tag, "_busy_end"}, 129'(busy), 129'(0));
        check({tag, "_q_hold"}, q_out, exp_q);
        check({tag, "_nreq"}, 129'(n_req), 129'(exp_ops.size()));
        bad = 0;
        for (int i = 0; i < op_log.size() && i < exp_ops.size(); i++) begin
            if (op_log[i] != exp_ops[i]) bad++;
            if (op_log[i] == OP_ADD && q_log[i] != pp) bad++;
        end
        check({tag, "_seq"}, 129'(bad), 129'(0));
    endtask

    initial begin
        logic [128:0] p1;
        logic [63:0]  rk;
        int           tmo;
        int           nb;
        p1    = {1'b0, 64'd1, 64'd0};
        rst   = 1'b0;
        start = 1'b0;
        k     = '0;
        p_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 129'(busy), 129'(0));
        check("rst_done", 129'(done), 129'(0));
        check("rst_en", 129'(ad_enable), 129'(0));
        check("rst_op", 129'(ad_op), 129'(OP_ADD));
        check("rst_q_out", q_out, INF);
        rst = 1'b1;
        @(negedge clk);

        run_mult("k0", 64'd0, {1'b0, 64'd93, 64'd9}, 0);
        run_mult("k1", 64'd1, {1'b0, 64'd93, 64'd9}, 0);
        run_mult("k5", 64'd5, p1, 0);
        run_mult("kff", 64'hFFFF_FFFF_FFFF_FFFF, p1, 0);
        run_mult("pinf", 64'd9, {1'b1, 64'd4, 64'd4}, 0);
        run_mult("k5_poke", 64'd5, p1, 10);
        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom} >> $urandom_range(63, 0);
            run_mult($sformatf("rnd%0d", i), rk,
                     {1'b0, $urandom, $urandom, $urandom, $urandom}, 0);
        end

        // Asynchronous reset while a double is in flight.
        op_log.delete();
        q_log.delete();
        n_req = 0;
        @(negedge clk);
        k     = 64'd6;
        p_in  = p1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tmo   = 0;
        while (n_req == 0 && tmo < 500) begin
            @(negedge clk);
            tmo++;
        end
        check("rst_first_dbl", 129'(op_log.size() > 0 && op_log[0] == OP_DBL), 129'(1));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 129'(busy), 129'(0));
        check("arst_en", 129'(ad_enable), 129'(0));
        check("arst_op", 129'(ad_op), 129'(OP_ADD));
        check("arst_p", ad_p, 129'(0));
        check("arst_q", ad_q, 129'(0));
        check("arst_q_out", q_out, INF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        nb  = n_req;
        repeat (12) @(negedge clk);
        check("stale_nreq", 129'(n_req), 129'(nb));
        check("stale_busy", 129'(busy), 129'(0));
        check("stale_done", 129'(done), 129'(0));
        run_mult("k3_after_rst", 64'd3, p1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
